// File: rtl/half_substractor.sv
// Registered 1-bit half subtractor (a - b) with a valid qualifier.
// Optional saturating borrow-event counter enabled by defining HALF_SUB_STATS_EN.
module half_substractor #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a,
    input  logic              b,
    input  logic              in_valid,
    output logic              subtr,
    output logic              carry,
    output logic              out_valid,
    output logic [STAT_W-1:0] borrow_cnt
);

    // Operands are only looked at when in_valid is high, so X/Z on idle cycles cannot leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            subtr     <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                subtr <= a ^ b;
                carry <= ~a & b;
            end
        end
    end

`ifdef HALF_SUB_STATS_EN
    logic [STAT_W-1:0] borrow_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            borrow_cnt_q <= '0;
        end else if (in_valid && !a && b && (borrow_cnt_q != {STAT_W{1'b1}})) begin
            borrow_cnt_q <= borrow_cnt_q + 1'b1;
        end
    end

    assign borrow_cnt = borrow_cnt_q;
`else
    assign borrow_cnt = '0;
`endif

endmodule

// File: tb/tb_half_substractor.sv
// Self-checking bench for half_substractor: directed scenarios plus a randomized
// stream checked against an arithmetic reference model (a - b on integers).
`timescale 1ns/1ps
module tb_half_substractor;

    localparam int STAT_W  = 2;
    localparam int CNT_MAX = (1 << STAT_W) - 1;
`ifdef HALF_SUB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              a;
    logic              b;
    logic              in_valid;
    logic              subtr;
    logic              carry;
    logic              out_valid;
    logic [STAT_W-1:0] borrow_cnt;

    int checks = 0;
    int errors = 0;

    logic exp_subtr;
    logic exp_carry;
    logic exp_valid;
    int   exp_cnt;

    half_substractor #(.STAT_W(STAT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .subtr      (subtr),
        .carry      (carry),
        .out_valid  (out_valid),
        .borrow_cnt (borrow_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance past the edge and update the model.
    task automatic cycle(input logic r, input logic av, input logic bv, input logic v);
        int d;
        @(negedge clk);
        rst      = r;
        a        = av;
        b        = bv;
        in_valid = v;
        @(posedge clk);
        #1;
        if (r) begin
            exp_subtr = 1'b0;
            exp_carry = 1'b0;
            exp_valid = 1'b0;
            exp_cnt   = 0;
        end else begin
            exp_valid = v;
            if (v) begin
                d = int'(av) - int'(bv);
                exp_subtr = (d != 0);
                exp_carry = (d < 0);
                if (STATS_ON && d < 0 && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1);
            checks++;
            if ({subtr, carry, out_valid, borrow_cnt} !== {1'b0, 1'b0, 1'b0, {STAT_W{1'b0}}}) begin
                errors++;
                $display("FAIL reset cycle %0d: got s=%b c=%b v=%b cnt=%0d, want all 0",
                         i, subtr, carry, out_valid, borrow_cnt);
            end
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] ab;
        logic [1:0] want [4];
        want[0] = 2'b00; want[1] = 2'b11; want[2] = 2'b10; want[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            cycle(1'b0, ab[1], ab[0], 1'b1);
            checks++;
            if ({subtr, carry, out_valid} !== {want[i], 1'b1}) begin
                errors++;
                $display("FAIL truth_table ab=%b: got s=%b c=%b v=%b, want s=%b c=%b v=1",
                         ab, subtr, carry, out_valid, want[i][1], want[i][0]);
            end
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({subtr, carry, out_valid} !== 3'b110) begin
            errors++;
            $display("FAIL hold: got s=%b c=%b v=%b, want s=1 c=1 v=0", subtr, carry, out_valid);
        end
        cycle(1'b0, 1'bx, 1'bz, 1'b0);
        checks++;
        if ({subtr, carry, out_valid} !== 3'b110) begin
            errors++;
            $display("FAIL hold_xz: got s=%b c=%b v=%b, want s=1 c=1 v=0", subtr, carry, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({subtr, carry, out_valid, borrow_cnt} !== {3'b000, {STAT_W{1'b0}}}) begin
            errors++;
            $display("FAIL mid_reset: got s=%b c=%b v=%b cnt=%0d, want all 0",
                     subtr, carry, out_valid, borrow_cnt);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({subtr, carry, out_valid} !== 3'b101) begin
            errors++;
            $display("FAIL after_reset: got s=%b c=%b v=%b, want s=1 c=0 v=1", subtr, carry, out_valid);
        end
    endtask

    task automatic test_stats();
        int want_seq [5];
        want_seq = '{1, 2, 3, 3, 3};
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (int'(borrow_cnt) !== (STATS_ON ? want_seq[i] : 0)) begin
                errors++;
                $display("FAIL stats_count step %0d: got %0d, want %0d",
                         i, borrow_cnt, STATS_ON ? want_seq[i] : 0);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (int'(borrow_cnt) !== (STATS_ON ? 1 : 0)) begin
            errors++;
            $display("FAIL stats_unchanged: got %0d, want %0d", borrow_cnt, STATS_ON ? 1 : 0);
        end
    endtask

    task automatic test_random();
        logic r, av, bv, v;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 29) == 0);
            av = 1'($urandom);
            bv = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            cycle(r, av, bv, v);
            checks++;
            if ({subtr, carry, out_valid} !== {exp_subtr, exp_carry, exp_valid} ||
                int'(borrow_cnt) !== exp_cnt) begin
                errors++;
                $display("FAIL random cycle %0d: got s=%b c=%b v=%b cnt=%0d, want s=%b c=%b v=%b cnt=%0d",
                         i, subtr, carry, out_valid, borrow_cnt,
                         exp_subtr, exp_carry, exp_valid, exp_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; in_valid = 1'b0;
        exp_subtr = 1'b0; exp_carry = 1'b0; exp_valid = 1'b0; exp_cnt = 0;
        test_reset();
        test_truth_table();
        test_hold();
        test_mid_reset();
        test_stats();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
